// File: rtl/serial_paralelo_if.sv
// Serial receive link bundle: 1-bit stream in, recovered byte plus status out.
// The receiver uses the slave modport; the stream source and observer use master.
interface serial_paralelo_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active
  );
endinterface

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: aligns to COM symbols, locks after BC_LOCK aligned COMs.
// Optional build macro SERIAL_RX_IDLE_HOLD_EN keeps the last payload on data_out during idle COMs.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_SEARCH | sliding 8-bit window checked every edge for COM
// ST_ALIGN  | byte boundary found, counting consecutive aligned COMs
// ST_ACTIVE | byte-locked; payload bytes presented, left only by reset
module serial_paralelo #(
  parameter logic [7:0]  COM     = 8'hBC,
  parameter int unsigned BC_LOCK = 4
) (
  input  logic             dclk,
  input  logic             reset_L,
  serial_paralelo_if.slave bus
);

  localparam logic [2:0] LP_LOCK = 3'(BC_LOCK);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_sr;
  logic [2:0] r_bit_cnt;
  logic [2:0] r_bc_cnt;
  logic [7:0] r_data_out;
  logic       r_valid_out;
  logic       r_active;

  logic [7:0] w_nxt;
  logic       w_is_com;
  logic       w_byte_done;

  assign w_nxt       = {r_sr[6:0], bus.data_in};
  assign w_is_com    = (w_nxt == COM);
  assign w_byte_done = (r_bit_cnt == 3'd7);

  always_ff @(posedge dclk or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= ST_SEARCH;
      r_sr        <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_bc_cnt    <= 3'd0;
      r_data_out  <= 8'h00;
      r_valid_out <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_sr <= w_nxt;
      case (r_state)
        ST_SEARCH: begin
          if (w_is_com) begin
            r_bit_cnt <= 3'd0;
            r_bc_cnt  <= 3'd1;
            r_state   <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_byte_done) begin
            if (w_is_com) begin
              if (r_bc_cnt == LP_LOCK - 3'd1) begin
                r_bc_cnt <= LP_LOCK;
                r_state  <= ST_ACTIVE;
                r_active <= 1'b1;
              end else begin
                r_bc_cnt <= r_bc_cnt + 3'd1;
              end
            end else begin
              r_bc_cnt <= 3'd0;
              r_state  <= ST_SEARCH;
            end
          end
        end
        ST_ACTIVE: begin
          // Unaligned COMs are ignored here; only byte boundaries matter.
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_byte_done) begin
            if (w_is_com) begin
              r_valid_out <= 1'b0;
`ifdef SERIAL_RX_IDLE_HOLD_EN
              r_data_out  <= r_data_out;
`else
              r_data_out  <= 8'h00;
`endif
            end else begin
              r_data_out  <= w_nxt;
              r_valid_out <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_SEARCH;
        end
      endcase
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.valid_out = r_valid_out;
  assign bus.active    = r_active;

endmodule

// File: tb/tb_serial_paralelo.sv
// Bench for serial_paralelo: directed link scenarios plus randomized streams,
// checked every bit edge against a bit-history reference model.
module tb_serial_paralelo;
  localparam logic [7:0] COM     = 8'hBC;
  localparam int         BC_LOCK = 4;
`ifdef SERIAL_RX_IDLE_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic dclk    = 1'b0;
  logic reset_L = 1'b0;

  serial_paralelo_if bus();

  serial_paralelo #(.COM(COM), .BC_LOCK(BC_LOCK)) u_dut (
    .dclk    (dclk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 dclk = ~dclk;

  bit hist[$];
  int n_assert = 0;
  int n_fail   = 0;

  // 8-bit window seen after edge e (bit hist[e-1] is the newest, zeros before reset).
  function automatic logic [7:0] win(int e);
    logic [7:0] w;
    w = 8'h00;
    for (int i = e - 8; i < e; i++)
      w = {w[6:0], (i >= 0 && i < hist.size()) ? hist[i] : 1'b0};
    return w;
  endfunction

  // Lock edge = 4th of four COM windows spaced 8 edges apart, the first found by
  // a sliding search; a failed chain restarts the search on the next edge.
  function automatic void model(output logic act, output logic vld, output logic [7:0] dat);
    int n, lock, s, e, j;
    bit stop, ok;
    n = hist.size(); lock = -1; s = 1; stop = 0;
    act = 1'b0; vld = 1'b0; dat = 8'h00;
    while (!stop && lock < 0 && s <= n) begin
      e = -1;
      for (int k = s; k <= n; k++)
        if (win(k) == COM) begin e = k; break; end
      if (e < 0) stop = 1;
      else begin
        ok = 1;
        for (j = 1; j < BC_LOCK; j++) begin
          if (e + 8*j > n) begin stop = 1; ok = 0; break; end
          if (win(e + 8*j) != COM) begin s = e + 8*j + 1; ok = 0; break; end
        end
        if (ok) lock = e + 8*(BC_LOCK-1);
      end
    end
    if (lock < 0) return;
    act = 1'b1;
    for (int b = lock + 8; b <= n; b += 8) begin
      if (win(b) != COM) begin dat = win(b); vld = 1'b1; end
      else begin vld = 1'b0; if (!HOLD) dat = 8'h00; end
    end
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at bit %0d: observed %h expected %h", tag, hist.size(), obs, exp);
    end
  endtask

  task automatic check_all();
    logic ea, ev;
    logic [7:0] ed;
    model(ea, ev, ed);
    chk("active", {7'd0, bus.active}, {7'd0, ea});
    chk("valid_out", {7'd0, bus.valid_out}, {7'd0, ev});
    chk("data_out", bus.data_out, ed);
  endtask

  task automatic send_bit(bit b);
    @(negedge dclk);
    bus.data_in = b;
    reset_L     = 1'b1;
    @(posedge dclk);
    hist.push_back(b);
    #1 check_all();
  endtask

  task automatic send_byte(logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_reset();
    @(negedge dclk);
    #1 reset_L = 1'b0;
    #1;
    chk("rst_data_out", bus.data_out, 8'h00);
    chk("rst_valid_out", {7'd0, bus.valid_out}, 8'h00);
    chk("rst_active", {7'd0, bus.active}, 8'h00);
    hist.delete();
    @(posedge dclk);
  endtask

  initial begin
    logic [7:0] rb;
    bus.data_in = 1'b0;
    #1;
    chk("init_data_out", bus.data_out, 8'h00);
    chk("init_active", {7'd0, bus.active}, 8'h00);
    @(posedge dclk);

    // Lock: active exactly on bit 32, A5 on bit 40, then idle and back-to-back payload.
    repeat (3) send_byte(COM);
    for (int i = 7; i >= 1; i--) send_bit(COM[i]);
    chk("pre_lock_bit31", {7'd0, bus.active}, 8'h00);
    send_bit(COM[0]);
    chk("lock_bit32", {7'd0, bus.active}, 8'h01);
    send_byte(8'hA5);
    chk("a5_data", bus.data_out, 8'hA5);
    chk("a5_valid", {7'd0, bus.valid_out}, 8'h01);
    send_byte(COM);
    chk("idle_valid", {7'd0, bus.valid_out}, 8'h00);
    chk("idle_data", bus.data_out, HOLD ? 8'hA5 : 8'h00);
    send_byte(8'hFF);
    send_byte(8'h00);
    chk("b2b_zero_valid", {7'd0, bus.valid_out}, 8'h01);
    send_byte(COM);
    send_byte(8'h81);
    chk("b2b_81", bus.data_out, 8'h81);
    for (int i = 7; i >= 4; i--) send_bit(COM[i]);

    // Mid-stream reset, then broken preamble followed by a good one.
    do_reset();
    repeat (3) send_byte(COM);
    send_byte(8'h00);
    chk("broken_active", {7'd0, bus.active}, 8'h00);
    repeat (4) send_byte(COM);
    send_byte(8'h3C);
    chk("relock_3c", bus.data_out, 8'h3C);

    // Misaligned start.
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    repeat (4) send_byte(COM);
    send_byte(8'h5A);
    chk("misalign_5a", bus.data_out, 8'h5A);
    chk("misalign_active", {7'd0, bus.active}, 8'h01);

    // Randomized streams: junk bits, optional broken preamble, lock, mixed payload.
    for (int t = 0; t < 8; t++) begin
      do_reset();
      repeat ($urandom_range(0, 7)) send_bit(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) send_byte(COM);
        rb = 8'($urandom_range(0, 255));
        if (rb == COM) rb = 8'h00;
        send_byte(rb);
      end
      repeat (BC_LOCK) send_byte(COM);
      for (int k = 0; k < 10; k++) begin
        rb = ($urandom_range(0, 3) == 0) ? COM : 8'($urandom_range(0, 255));
        send_byte(rb);
      end
      if ($urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, 7)) send_bit(1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_paralelo.md
# serial_paralelo

Serial-to-parallel receiver for the physical-layer link. It deserializes the 1-bit stream produced by the parallel-to-serial transmitter in `main` back into bytes. It aligns to byte boundaries using the COM symbol 0xBC and declares the link active after four aligned COMs. In the link's receive path it sits directly downstream of the transmitter's `data_out`, in the serial (`dclk`) domain.

## Interface
- `COM`, 8'hBC: comma/idle symbol used for alignment and as the idle filler.
- `BC_LOCK`, 4: number of consecutive byte-aligned COMs required to enter ACTIVE.
- `dclk` input 1: serial bit clock. All state updates on the rising edge.
- `reset_L` input 1: asynchronous, active-low reset.
- `data_in` input 1: serial data, MSB first, one bit per `dclk`.
- `data_out` output 8: recovered byte.
- `valid_out` output 1: `data_out` carries a non-COM payload byte.
- `active` output 1: receiver is byte-locked (ACTIVE state).

## Operation
- Shift register: `nxt = {sr[6:0], data_in}`, and `sr <= nxt` on every edge.
- Bit counter `bit_cnt` is 3 bits and wraps modulo 8. A byte completes on the edge where `bit_cnt == 7`.
- `bc_cnt` is 3 bits, counts from 0 to `BC_LOCK`, and never wraps.
- States are SEARCH, ALIGN and ACTIVE.
- SEARCH:
  - Checks `nxt` on every edge, not only at byte boundaries.
  - If `nxt == COM`: `bit_cnt <= 0`, `bc_cnt <= 1`, go to ALIGN.
  - Otherwise: stay in SEARCH.
- ALIGN:
  - `bit_cnt` increments each edge.
  - At byte completion with `nxt == COM`: `bc_cnt++`. When `bc_cnt` reaches `BC_LOCK`, go to ACTIVE and set `active <= 1` on that same edge.
  - At byte completion with `nxt != COM`: `bc_cnt <= 0`, go to SEARCH. No output is produced.
- ACTIVE:
  - At byte completion with `nxt != COM`: `data_out <= nxt`, `valid_out <= 1`.
  - At byte completion with `nxt == COM`: `valid_out <= 0`. `data_out` follows the Configuration section.
  - Between byte boundaries, `data_out` and `valid_out` hold.
  - ACTIVE is left only by reset. A COM seen at an unaligned position while ACTIVE is ignored.
- Reset (asynchronous, effective immediately, including mid-byte):
  - `sr = 0`, `bit_cnt = 0`, `bc_cnt = 0`, state SEARCH.
  - `data_out = 8'h00`, `valid_out = 0`, `active = 0`.

## Timing
- Latency: the byte is presented on the same edge that samples its LSB. Outputs are registered, so they are visible right after that edge.
- `valid_out` and `data_out` are stable for exactly 8 `dclk` cycles per byte. There is no single-cycle strobe.
- Fastest lock: the first COM's last bit arrives at edge N. ALIGN is entered at edge N. `active` rises at edge N+24, on the 4th COM.
- A payload byte starting right after lock appears at edge N+32.
- Simultaneous events: if `reset_L` is deasserted on the same edge as a `data_in` transition, the first bit is sampled on the following edge.

## Configuration
- Macro: `SERIAL_RX_IDLE_HOLD_EN`.
- When defined: on a COM byte in ACTIVE, `data_out` holds the last payload byte while `valid_out = 0`.
- When undefined: on a COM byte in ACTIVE, `data_out <= 8'h00` while `valid_out = 0`.
- All other behaviour is identical in both builds.

## Test plan
- Reset: assert `reset_L = 0` mid-stream. Required: `data_out = 00`, `valid_out = 0`, `active = 0` immediately, without waiting for a clock edge.
- Lock: send BC×4 then A5. Required:
  - `active` rises on the 32nd bit edge.
  - `data_out = A5` and `valid_out = 1` after the 40th bit, held for 8 cycles.
- Broken preamble: send BC×3 then 00. Required: `active` stays 0 and the receiver returns to SEARCH. A following BC×4, 3C then locks and outputs `3C`.
- Bit misalignment: send 3 junk bits `101`, then BC×4, then 5A. Required: lock is achieved and `data_out = 5A`.
- Idle in ACTIVE: after A5, send BC. Required:
  - `valid_out = 0` in both builds.
  - `data_out = A5` with `SERIAL_RX_IDLE_HOLD_EN` defined.
  - `data_out = 00` without it.
- Back-to-back payload: send FF, 00, BC, 81 after lock. Required:
  - `data_out` sequence is FF, 00, (idle), 81.
  - `valid_out` sequence is 1, 1, 0, 1, each held for 8 cycles.
